// File: rtl/fft16_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft16_frame_sequencer_pkg
// Description : Shared sizes, state encoding and lane-reorder helper for the
//               16-point FFT frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fft16_frame_sequencer_pkg;

    localparam int N_DEFAULT       = 16;
    localparam int STAGES_DEFAULT  = 4;
    localparam int TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4
    } seq_state_e;

    // The core emits bins in bit-reversed lane order.
    function automatic logic [3:0] bitrev4(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft16_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft16_frame_sequencer
// Description : Frames a serial complex sample stream for the FFT16 core and
//               streams the results back out in natural bin order.
// Revision    : 1.0 - initial release
// ============================================================================
module fft16_frame_sequencer
    import fft16_frame_sequencer_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int STAGES  = STAGES_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_s_valid,
    output logic                          o_s_ready,
    input  logic [N-1:0]                  i_s_re,
    input  logic [N-1:0]                  i_s_im,
    output logic                          o_fft_start,
    output logic [(1<<STAGES)*N-1:0]      o_fft_in_re,
    output logic [(1<<STAGES)*N-1:0]      o_fft_in_im,
    input  logic                          i_fft_done,
    input  logic [(1<<STAGES)*N-1:0]      i_fft_out_re,
    input  logic [(1<<STAGES)*N-1:0]      i_fft_out_im,
    output logic                          o_m_valid,
    input  logic                          i_m_ready,
    output logic [2*N-1:0]                o_m_data,
    output logic [STAGES-1:0]             o_m_index,
    output logic                          o_m_last,
    output logic                          o_busy,
    output logic                          o_timeout
);

    localparam int LANES = 1 << STAGES;
    localparam int TW    = $clog2(TIMEOUT);

    seq_state_e             state_q, state_d;
    logic [STAGES-1:0]      wr_idx_q, wr_idx_d;
    logic [STAGES-1:0]      rd_idx_q, rd_idx_d;
    logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic [LANES*N-1:0]     frame_re_q, frame_re_d, frame_im_q, frame_im_d;
    logic [LANES*N-1:0]     res_re_q, res_re_d, res_im_q, res_im_d;
    logic                   s_ready_q, s_ready_d;
    logic                   fft_start_q, fft_start_d;
    logic                   m_valid_q, m_valid_d;
    logic [2*N-1:0]         m_data_q, m_data_d;
    logic [STAGES-1:0]      m_index_q, m_index_d;
    logic                   m_last_q, m_last_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        tmo_cnt_d  = tmo_cnt_q;
        frame_re_d = frame_re_q;
        frame_im_d = frame_im_q;
        res_re_d   = res_re_q;
        res_im_d   = res_im_q;
        timeout_d  = timeout_q;

        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: begin
                if (i_s_valid && s_ready_q) begin
                    frame_re_d[wr_idx_q*N +: N] = i_s_re;
                    frame_im_d[wr_idx_q*N +: N] = i_s_im;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == STAGES'(LANES-1)) state_d = ST_START;
                end
            end
            ST_START: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the final timeout cycle still wins.
                if (i_fft_done) begin
                    for (int k = 0; k < LANES; k++) begin
                        res_re_d[k*N +: N] = i_fft_out_re[int'(bitrev4(4'(k)))*N +: N];
                        res_im_d[k*N +: N] = i_fft_out_im[int'(bitrev4(4'(k)))*N +: N];
                    end
                    rd_idx_d = '0;
                    state_d  = ST_UNLOAD;
                end else if (tmo_cnt_q == TW'(TIMEOUT-1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_LOAD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_UNLOAD: begin
                if (m_valid_q && i_m_ready) begin
                    if (m_last_q) state_d  = ST_LOAD;
                    else          rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        s_ready_d   = (state_d == ST_LOAD);
        fft_start_d = (state_d == ST_START);
        busy_d      = (state_d != ST_LOAD);
        m_valid_d   = (state_d == ST_UNLOAD);
        m_data_d    = '0;
        m_index_d   = '0;
        m_last_d    = 1'b0;
        if (state_d == ST_UNLOAD) begin
            m_data_d  = {res_re_d[rd_idx_d*N +: N], res_im_d[rd_idx_d*N +: N]};
            m_index_d = rd_idx_d;
            m_last_d  = (rd_idx_d == STAGES'(LANES-1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            tmo_cnt_q   <= '0;
            frame_re_q  <= '0;
            frame_im_q  <= '0;
            res_re_q    <= '0;
            res_im_q    <= '0;
            s_ready_q   <= 1'b0;
            fft_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_index_q   <= '0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            tmo_cnt_q   <= tmo_cnt_d;
            frame_re_q  <= frame_re_d;
            frame_im_q  <= frame_im_d;
            res_re_q    <= res_re_d;
            res_im_q    <= res_im_d;
            s_ready_q   <= s_ready_d;
            fft_start_q <= fft_start_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_index_q   <= m_index_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_s_ready   = s_ready_q;
    assign o_fft_start = fft_start_q;
    assign o_fft_in_re = frame_re_q;
    assign o_fft_in_im = frame_im_q;
    assign o_m_valid   = m_valid_q;
    assign o_m_data    = m_data_q;
    assign o_m_index   = m_index_q;
    assign o_m_last    = m_last_q;
    assign o_busy      = busy_q;
    assign o_timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_fft16_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft16_frame_sequencer
// Description : Directed/randomized bench with an FFT core stub and a
//               bin-order reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft16_frame_sequencer;

    localparam int N   = 16;
    localparam int STG = 4;
    localparam int P   = 16;
    localparam int TMO = 16;
    localparam int L   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid, s_ready;
    logic [N-1:0]     s_re, s_im;
    logic             fft_start, fft_done;
    logic [P*N-1:0]   fin_re, fin_im, fout_re, fout_im;
    logic             m_valid, m_ready, m_last, busy, tmo;
    logic [2*N-1:0]   m_data;
    logic [STG-1:0]   m_index;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fft16_frame_sequencer #(.N(N), .STAGES(STG), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_re(s_re), .i_s_im(s_im),
        .o_fft_start(fft_start), .o_fft_in_re(fin_re), .o_fft_in_im(fin_im),
        .i_fft_done(fft_done), .i_fft_out_re(fout_re), .i_fft_out_im(fout_im),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
        .o_m_index(m_index), .o_m_last(m_last), .o_busy(busy), .o_timeout(tmo)
    );

    // Core stub: latches the frame on start, pulses done L cycles later.
    logic [P*N-1:0] cap_re, cap_im;
    int             stub_cnt;
    bit             stub_en   = 1'b1;
    int             stub_mode = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt <= 0;
            fft_done <= 1'b0;
            cap_re   <= '0;
            cap_im   <= '0;
        end else begin
            fft_done <= 1'b0;
            if (fft_start) begin
                stub_cnt <= 1;
                cap_re   <= fin_re;
                cap_im   <= fin_im;
            end else if (stub_cnt != 0) begin
                if (stub_cnt == L-1) begin
                    stub_cnt <= 0;
                    fft_done <= stub_en;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end
        end
    end

    always_comb begin
        fout_re = '0;
        fout_im = '0;
        for (int j = 0; j < P; j++) begin
            case (stub_mode)
                0: begin
                    fout_re[j*N +: N] = cap_re[j*N +: N];
                    fout_im[j*N +: N] = cap_im[j*N +: N];
                end
                1: begin
                    fout_re[j*N +: N] = N'(j);
                    fout_im[j*N +: N] = N'(j + 256);
                end
                default: begin
                    fout_re[j*N +: N] = cap_re[N-1:0];
                    fout_im[j*N +: N] = cap_im[N-1:0];
                end
            endcase
        end
    end

    // Reference model
    logic [N-1:0] fr_re [P];
    logic [N-1:0] fr_im [P];

    function automatic int rev(input int k);
        int r = 0;
        for (int b = 0; b < STG; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    function automatic logic [2*N-1:0] exp_bin(input int k);
        case (stub_mode)
            0:       return {fr_re[rev(k)], fr_im[rev(k)]};
            1:       return {N'(rev(k)), N'(rev(k) + 256)};
            default: return {fr_re[0], fr_im[0]};
        endcase
    endfunction

    task automatic new_frame(input bit impulse);
        for (int i = 0; i < P; i++) begin
            fr_re[i] = impulse ? ((i == 0) ? 16'h0100 : 16'h0000) : N'($urandom);
            fr_im[i] = impulse ? 16'h0000 : N'($urandom);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit gaps);
        int i = 0;
        int g = 0;
        bit hs;
        logic [P*N-1:0] e_re, e_im;
        while (i < P && g < 500) begin
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_re    = fr_re[i];
            s_im    = fr_im[i];
            hs      = s_valid && s_ready;
            step();
            if (hs) i++;
            g++;
        end
        s_valid = 1'b0;
        chk("load_count", 64'(i), 64'(P));
        chk("start_pulse", 64'(fft_start), 64'd1);
        chk("ready_drop", 64'(s_ready), 64'd0);
        for (int k = 0; k < P; k++) begin
            e_re[k*N +: N] = fr_re[k];
            e_im[k*N +: N] = fr_im[k];
        end
        n_chk++;
        assert ({fin_re, fin_im} === {e_re, e_im}) else begin
            n_fail++;
            $error("FAIL fft_in_frame: observed %h expected %h", {fin_re, fin_im}, {e_re, e_im});
        end
    endtask

    task automatic collect(input int rmode, input int stop_at);
        int k  = 0;
        int g  = 0;
        int vc = 0;
        bit hs;
        bit stalled = 1'b0;
        logic [2*N-1:0] prev = '0;
        while (k < stop_at && g < 2000) begin
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = (vc == 0 || vc == 2 || vc >= 13);
            endcase
            if (m_valid) begin
                if (stalled) chk("stall_stable", 64'(m_data), 64'(prev));
                chk("bin_data", 64'(m_data), 64'(exp_bin(k)));
                chk("bin_index", 64'(m_index), 64'(k));
                chk("bin_last", 64'(m_last), 64'(k == P-1));
                vc++;
            end
            hs      = m_valid && m_ready;
            stalled = m_valid && !m_ready;
            prev    = m_data;
            step();
            if (hs) k++;
            g++;
        end
        m_ready = 1'b0;
        chk("collect_count", 64'(k), 64'(stop_at));
        if (stop_at == P) begin
            chk("valid_drop", 64'(m_valid), 64'd0);
            chk("ready_back", 64'(s_ready), 64'd1);
            chk("busy_low", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_re    = '0;
        s_im    = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_timeout", 64'(tmo), 64'd0);
        chk("rst_start", 64'(fft_start), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        rst_n = 1'b1;
        chk("rel_ready0", 64'(s_ready), 64'd0);
        step();
        chk("rel_ready1", 64'(s_ready), 64'd1);

        // Impulse frame with exact launch and output latency
        stub_mode = 2;
        new_frame(1'b1);
        send_frame(1'b0);
        step();
        chk("start_once", 64'(fft_start), 64'd0);
        chk("busy_wait", 64'(busy), 64'd1);
        repeat (4) step();
        chk("valid_early", 64'(m_valid), 64'd0);
        step();
        chk("valid_latency", 64'(m_valid), 64'd1);
        collect(0, P);

        // Lane-number stub exposes the bit-reversal undo
        stub_mode = 1;
        new_frame(1'b0);
        send_frame(1'b1);
        collect(1, P);

        // Random data, sink pattern 1-0-1 then 10 stalled cycles
        stub_mode = 0;
        new_frame(1'b0);
        send_frame(1'b1);
        collect(2, P);

        // Core never answers
        stub_en = 1'b0;
        new_frame(1'b0);
        send_frame(1'b0);
        repeat (16) step();
        chk("tmo_not_yet", 64'(tmo), 64'd0);
        chk("tmo_busy", 64'(busy), 64'd1);
        step();
        chk("tmo_set", 64'(tmo), 64'd1);
        chk("tmo_ready", 64'(s_ready), 64'd1);
        chk("tmo_idle", 64'(busy), 64'd0);
        stub_en = 1'b1;
        new_frame(1'b0);
        send_frame(1'b0);
        collect(1, P);
        chk("tmo_sticky", 64'(tmo), 64'd1);

        // Reset while bin 6 is on the output
        new_frame(1'b0);
        send_frame(1'b0);
        collect(0, 6);
        chk("pre_rst_index", 64'(m_index), 64'd6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_data", 64'(m_data), 64'd0);
        chk("mid_rst_index", 64'(m_index), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_tmo", 64'(tmo), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rel_ready0", 64'(s_ready), 64'd0);
        step();
        chk("mid_rel_ready1", 64'(s_ready), 64'd1);

        // Recovery frame
        new_frame(1'b0);
        send_frame(1'b1);
        collect(1, P);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
